// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: stage FSM encoding,
// the canonical NOP instruction and the per-stage payload layouts.
package pipe_pkg;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_result;
    logic [26:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer,
// flush-to-NOP bubble and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = EX_MEM_W,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
  parameter bit                SKID        = 1'b1,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_payload,
  output logic              out_flushed,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr,
  output state_e            state_dbg
);

  // Handshake: a beat moves on a side only in a cycle where that side's
  // valid and ready are both 1; valid never waits on ready, and a held
  // out_payload stays stable until consumed. Flush overrides everything.
  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q, flushed_q;
  logic              in_ready_raw;
  logic              accept, consume;

  // In skid mode in_ready comes from a flop; flush forces it high so the
  // upstream sees its (discarded) beat as taken.
  always_comb begin
    in_ready_raw = SKID ? in_ready_q : ((state_q == pipe_pkg::EMPTY) || out_ready);
  end

  assign in_ready    = in_ready_raw | flush;
  assign out_valid   = (state_q != pipe_pkg::EMPTY);
  assign out_payload = main_q;
  assign out_flushed = flushed_q;
  assign state_dbg   = state_q;
  assign accept      = in_valid && in_ready_raw && !flush;
  assign consume     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      pipe_pkg::EMPTY: if (accept) state_d = pipe_pkg::FULL;
      pipe_pkg::FULL: begin
        if (accept && !consume)      state_d = pipe_pkg::SKID;
        else if (!accept && consume) state_d = pipe_pkg::EMPTY;
      end
      pipe_pkg::SKID:  if (consume) state_d = pipe_pkg::FULL;
      default:         state_d = pipe_pkg::EMPTY;
    endcase
    if (flush) state_d = pipe_pkg::EMPTY;
  end

  always_comb begin
    case (state_q)
      pipe_pkg::FULL: occupancy = 2'd1;
      pipe_pkg::SKID: occupancy = 2'd2;
      default:        occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= pipe_pkg::EMPTY;
      main_q     <= NOP_PAYLOAD;
      skid_q     <= NOP_PAYLOAD;
      in_ready_q <= 1'b1;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != pipe_pkg::SKID);
      if (flush) begin
        main_q    <= NOP_PAYLOAD;
        skid_q    <= NOP_PAYLOAD;
        flushed_q <= 1'b1;
      end else begin
        if (accept) flushed_q <= 1'b0;
        case (state_q)
          pipe_pkg::EMPTY: if (accept) main_q <= in_payload;
          pipe_pkg::FULL: begin
            if (accept && consume) main_q <= in_payload;
            else if (accept)       skid_q <= in_payload;
          end
          pipe_pkg::SKID:  if (consume) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid and no-skid instances plus a
// narrow-counter instance sharing the skid-mode stimulus.
module tb_pipe_stage_elastic;

  localparam int W = 16;
  localparam logic [W-1:0] NOP = 16'h0013;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic flush = 1'b0, cnt_clr = 1'b0;

  // skid instance (also drives the 3-bit counter instance)
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_payload = '0;
  logic          in_ready, out_valid, out_flushed;
  logic [W-1:0]  out_payload;
  logic [1:0]    occupancy;
  logic [31:0]   stall_cnt;
  pipe_pkg::state_e state_dbg;

  logic          s_in_ready, s_out_valid, s_out_flushed;
  logic [W-1:0]  s_out_payload;
  logic [1:0]    s_occ;
  logic [2:0]    s_stall;
  pipe_pkg::state_e s_state;

  // no-skid instance
  logic          n_valid = 1'b0, n_ready = 1'b0;
  logic [W-1:0]  n_payload = '0;
  logic          n_in_ready, n_out_valid, n_flushed;
  logic [W-1:0]  n_out_payload;
  logic [1:0]    n_occ;
  logic [31:0]   n_stall;
  pipe_pkg::state_e n_state;

  pipe_stage_elastic #(.DATA_W(W), .NOP_PAYLOAD(NOP), .SKID(1'b1), .CNT_W(32)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_flushed(out_flushed), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .cnt_clr(cnt_clr), .state_dbg(state_dbg)
  );

  pipe_stage_elastic #(.DATA_W(W), .NOP_PAYLOAD(NOP), .SKID(1'b1), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_payload(in_payload), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_payload(s_out_payload), .out_flushed(s_out_flushed), .occupancy(s_occ),
    .stall_cnt(s_stall), .cnt_clr(cnt_clr), .state_dbg(s_state)
  );

  pipe_stage_elastic #(.DATA_W(W), .NOP_PAYLOAD(NOP), .SKID(1'b0), .CNT_W(32)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(n_valid), .in_ready(n_in_ready),
    .in_payload(n_payload), .out_valid(n_out_valid), .out_ready(n_ready),
    .out_payload(n_out_payload), .out_flushed(n_flushed), .occupancy(n_occ),
    .stall_cnt(n_stall), .cnt_clr(cnt_clr), .state_dbg(n_state)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_payload !== NOP) begin errors++; $display("FAIL reset_payload: got %h want %h", out_payload, NOP); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    checks++; if (out_flushed !== 1'b0) begin errors++; $display("FAIL reset_flushed: got %0b want 0", out_flushed); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_payload = 16'h00A5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if (out_payload !== 16'h00A5) begin errors++; $display("FAIL basic_payload: got %h want 00a5", out_payload); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ: got %0d want 1", occupancy); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_payload = 16'h0001; out_ready = 1'b1;
    step();
    in_payload = 16'h0002; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_full: got %0b want 1", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_low: got %0b want 0", in_ready); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ2: got %0d want 2", occupancy); end
    checks++; if (state_dbg !== pipe_pkg::SKID) begin errors++; $display("FAIL skid_state: got %0d want 2", state_dbg); end
    in_payload = 16'h0003;
    step();
    checks++; if (out_payload !== 16'h0001) begin errors++; $display("FAIL skid_stable: got %h want 0001", out_payload); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_hold: got %0b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_payload !== 16'h0002) begin errors++; $display("FAIL skid_second: got %h want 0002", out_payload); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL skid_occ1: got %0d want 1", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_payload !== 16'h0003 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_third: got %h/%0b want 0003/1", out_payload, out_valid); end
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL skid_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_payload = 16'h0011; out_ready = 1'b0;
    step();
    in_payload = 16'h0022;
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    flush = 1'b1; in_payload = 16'h0033;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    checks++; if (out_flushed !== 1'b1) begin errors++; $display("FAIL flush_flag: got %0b want 1", out_flushed); end
    checks++; if (out_payload !== NOP) begin errors++; $display("FAIL flush_payload: got %h want %h", out_payload, NOP); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    repeat (2) step();
    checks++; if (out_valid !== 1'b0 || out_flushed !== 1'b1) begin errors++; $display("FAIL flush_no_leak: got valid=%0b flushed=%0b want 0/1", out_valid, out_flushed); end
    in_valid = 1'b1; in_payload = 16'h0044;
    step();
    in_valid = 1'b0;
    checks++; if (out_flushed !== 1'b0) begin errors++; $display("FAIL flush_clear: got %0b want 0", out_flushed); end
    checks++; if (out_payload !== 16'h0044) begin errors++; $display("FAIL flush_next: got %h want 0044", out_payload); end
    step();
  endtask

  task automatic test_stall_counter();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 32'd0 || s_stall !== 3'd0) begin errors++; $display("FAIL stall_clr0: got %0d/%0d want 0/0", stall_cnt, s_stall); end
    in_valid = 1'b1; in_payload = 16'h0066; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (10) step();
    checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stall_10: got %0d want 10", stall_cnt); end
    checks++; if (s_stall !== 3'd7) begin errors++; $display("FAIL stall_sat10: got %0d want 7", s_stall); end
    repeat (2) step();
    checks++; if (stall_cnt !== 32'd12) begin errors++; $display("FAIL stall_12: got %0d want 12", stall_cnt); end
    checks++; if (s_stall !== 3'd7) begin errors++; $display("FAIL stall_sat12: got %0d want 7", s_stall); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 32'd0 || s_stall !== 3'd0) begin errors++; $display("FAIL stall_clr_prio: got %0d/%0d want 0/0", stall_cnt, s_stall); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (stall_cnt !== 32'd2 || s_stall !== 3'd2) begin errors++; $display("FAIL stall_flush_keep: got %0d/%0d want 2/2", stall_cnt, s_stall); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back_noskid();
    int delivered;
    logic accepted;
    logic [W-1:0] exp;
    delivered = 0;
    n_valid = 1'b1; n_payload = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      n_ready = i[0];
      #1;
      if (n_out_valid) begin
        checks++; if (n_in_ready !== n_ready) begin errors++; $display("FAIL nsk_ready cyc%0d: got %0b want %0b", i, n_in_ready, n_ready); end
      end
      if (n_out_valid && n_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL nsk_extra cyc%0d: got %h want none", i, n_out_payload); end
        else begin
          exp = exp_q.pop_front();
          delivered++;
          if (n_out_payload !== exp) begin errors++; $display("FAIL nsk_data cyc%0d: got %h want %h", i, n_out_payload, exp); end
        end
      end
      accepted = !n_out_valid || n_ready;
      if (accepted) exp_q.push_back(n_payload);
      step();
      if (accepted) n_payload = n_payload + 16'd1;
    end
    n_valid = 1'b0; n_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (n_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL nsk_drain_extra: got %h want none", n_out_payload); end
        else begin
          exp = exp_q.pop_front();
          delivered++;
          if (n_out_payload !== exp) begin errors++; $display("FAIL nsk_drain_data: got %h want %h", n_out_payload, exp); end
        end
      end
      step();
    end
    checks++; if (delivered != 11 || exp_q.size() != 0) begin errors++; $display("FAIL nsk_count: got %0d delivered, %0d left want 11, 0", delivered, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_payload = 16'h0077; out_ready = 1'b0;
    step();
    in_payload = 16'h0088;
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstmid_pre_occ: got %0d want 2", occupancy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_state: got valid=%0b occ=%0d want 0/0", out_valid, occupancy); end
    checks++; if (out_payload !== NOP || stall_cnt !== 32'd0 || out_flushed !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got %h/%0d/%0b want %h/0/0", out_payload, stall_cnt, out_flushed, NOP); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_payload = 16'h0055; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_payload !== 16'h0055) begin errors++; $display("FAIL rstmid_first: got %0b/%h want 1/0055", out_valid, out_payload); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_stall_counter();
    test_back_to_back_noskid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
